interrupt_controller: RTL and testbench

- Request side of the interrupt handshake consumed by the 8051 control unit's i_int_pend input.
- Synchronises and latches the five standard 8051 sources (INT0, TF0, INT1, TF1, RI|TI) and applies IE/IP masking and priority.
- Issues a one-cycle pending pulse with a vector address at instruction boundaries.
- Tracks in-service priority levels until the CU completes RETI.

---
 rtl/interrupt_controller.sv | 173 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// 8051-style interrupt request unit: synchronises and latches five sources, applies IE/IP masking and priority.
// Issues a one-cycle pending pulse plus vector at instruction boundaries. Optional macro: INTC_PREEMPT_EN.
module interrupt_controller #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'h0003,
  parameter int          VEC_STRIDE  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_int0_n,
  input  logic        i_int1_n,
  input  logic        i_tf0,
  input  logic        i_tf1,
  input  logic        i_ser,
  input  logic [7:0]  i_ie,
  input  logic [4:0]  i_ip,
  input  logic        i_it0,
  input  logic        i_it1,
  input  logic        i_boundary,
  input  logic        i_reti,
  output logic        o_int_pend,
  output logic [15:0] o_vector,
  output logic        o_tf0_clr,
  output logic        o_tf1_clr,
  output logic [1:0]  o_ie_flags,
  output logic [1:0]  o_in_service
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic                   prev0_q, prev1_q;
  logic                   ie0_q, ie1_q;
  logic [2:0]             win_idx_q, win_idx;
  logic                   win_hi_q, win_hi;
  logic [15:0]            vector_q, vec_calc;
  logic [1:0]             in_service_q, in_service_d;
  logic                   skip_q;
  logic                   pin0, pin1, fall0, fall1, clr0, clr1;
  logic [4:0]             flags, req, hi_req, pool;
  logic                   any_req, eligible, load, issuing;
  logic                   unused_ie;

  assign unused_ie = ^i_ie[6:5];

  // Pins idle high, so the chains and edge history preset to 1 to avoid a false edge out of reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync0_q <= '1;
      sync1_q <= '1;
      prev0_q <= 1'b1;
      prev1_q <= 1'b1;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], i_int0_n};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], i_int1_n};
      prev0_q <= sync0_q[SYNC_STAGES-1];
      prev1_q <= sync1_q[SYNC_STAGES-1];
    end
  end

  assign pin0  = sync0_q[SYNC_STAGES-1];
  assign pin1  = sync1_q[SYNC_STAGES-1];
  assign fall0 = prev0_q & ~pin0;
  assign fall1 = prev1_q & ~pin1;
  assign clr0  = issuing && (win_idx_q == 3'd0);
  assign clr1  = issuing && (win_idx_q == 3'd2);

  // A fresh edge wins over the vectoring clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ie0_q <= 1'b0;
      ie1_q <= 1'b0;
    end else begin
      ie0_q <= i_it0 ? (fall0 | (ie0_q & ~clr0)) : 1'b0;
      ie1_q <= i_it1 ? (fall1 | (ie1_q & ~clr1)) : 1'b0;
    end
  end

  assign flags   = {i_ser, i_tf1, (i_it1 ? ie1_q : ~pin1), i_tf0, (i_it0 ? ie0_q : ~pin0)};
  assign req     = flags & i_ie[4:0] & {5{i_ie[7]}};
  assign hi_req  = req & i_ip;
  assign any_req = |req;

  always_comb begin
    win_hi  = |hi_req;
    pool    = win_hi ? hi_req : req;
    win_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pool[i]) win_idx = 3'(i);
    end
  end

  always_comb begin
`ifdef INTC_PREEMPT_EN
    eligible = win_hi ? !in_service_q[1] : (in_service_q == 2'b00);
`else
    eligible = (in_service_q == 2'b00);
`endif
  end

  assign vec_calc = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, win_idx};

  // Request handshake: o_int_pend is a one-cycle pulse, no ready; the CU acknowledges implicitly by
  // executing at least one ISR instruction (next i_boundary) and later closes the level with i_reti.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issuing = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_boundary && !skip_q && any_req && eligible) begin
          state_d = S_ISSUE;
          load    = 1'b1;
        end
      end
      S_ISSUE: begin
        issuing = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (i_boundary) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      win_idx_q <= 3'd0;
      win_hi_q  <= 1'b0;
      vector_q  <= 16'h0000;
    end else if (load) begin
      win_idx_q <= win_idx;
      win_hi_q  <= win_hi;
      vector_q  <= vec_calc;
    end
  end

  // RETI clear is applied before the issue set so both can land in one cycle.
  always_comb begin
    in_service_d = in_service_q;
    if (i_reti) begin
      if (in_service_d[1]) in_service_d[1] = 1'b0;
      else                 in_service_d[0] = 1'b0;
    end
    if (issuing) in_service_d[win_hi_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_service_q <= 2'b00;
      skip_q       <= 1'b0;
    end else begin
      in_service_q <= in_service_d;
      if (i_reti)                                skip_q <= 1'b1;
      else if (i_boundary && state_q != S_ISSUE) skip_q <= 1'b0;
    end
  end

  assign o_int_pend   = issuing;
  assign o_vector     = vector_q;
  assign o_tf0_clr    = issuing && (win_idx_q == 3'd1);
  assign o_tf1_clr    = issuing && (win_idx_q == 3'd3);
  assign o_ie_flags   = {ie1_q, ie0_q};
  assign o_in_service = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: vector table, directed multi-cycle sequences,
// and randomized traffic compared against a behavioural model.
module tb_interrupt_controller;

  localparam int          SYNC       = 2;
  localparam logic [15:0] VBASE      = 16'h0003;
  localparam int          VSTRIDE    = 8;
`ifdef INTC_PREEMPT_EN
  localparam bit          PREEMPT    = 1'b1;
`else
  localparam bit          PREEMPT    = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_int0_n, i_int1_n, i_tf0, i_tf1, i_ser;
  logic [7:0]  i_ie;
  logic [4:0]  i_ip;
  logic        i_it0, i_it1, i_boundary, i_reti;
  logic        o_int_pend, o_tf0_clr, o_tf1_clr;
  logic [15:0] o_vector;
  logic [1:0]  o_ie_flags, o_in_service;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  interrupt_controller #(.SYNC_STAGES(SYNC), .VEC_BASE(VBASE), .VEC_STRIDE(VSTRIDE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_int0_n(i_int0_n), .i_int1_n(i_int1_n),
    .i_tf0(i_tf0), .i_tf1(i_tf1), .i_ser(i_ser), .i_ie(i_ie), .i_ip(i_ip),
    .i_it0(i_it0), .i_it1(i_it1), .i_boundary(i_boundary), .i_reti(i_reti),
    .o_int_pend(o_int_pend), .o_vector(o_vector), .o_tf0_clr(o_tf0_clr),
    .o_tf1_clr(o_tf1_clr), .o_ie_flags(o_ie_flags), .o_in_service(o_in_service)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge i_clk);
  endtask

  task automatic idle_inputs;
    i_int0_n = 1'b1; i_int1_n = 1'b1;
    i_tf0 = 1'b0; i_tf1 = 1'b0; i_ser = 1'b0;
    i_ie = 8'h00; i_ip = 5'h00;
    i_it0 = 1'b1; i_it1 = 1'b1;
    i_boundary = 1'b0; i_reti = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    i_rst = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
  endtask

  task automatic pulse_boundary;
    i_boundary = 1'b1;
    tick();
    i_boundary = 1'b0;
  endtask

  task automatic pulse_reti;
    i_reti = 1'b1;
    tick();
    i_reti = 1'b0;
  endtask

  task automatic pulse_int0;
    i_int0_n = 1'b0;
    repeat (3) tick();
    i_int0_n = 1'b1;
    repeat (3) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  ie;
    logic [4:0]  ip;
    logic        tf0, tf1, ser;
    logic        exp_pend;
    logic [15:0] exp_vec;
    logic        exp_tf0clr, exp_tf1clr;
    logic [1:0]  exp_ins;
  } vec_t;

  vec_t tbl[8];

  // ---------------- behavioural reference model ----------------
  bit          q0[$], q1[$];
  int          m_phase;      // 0 waiting, 1 request pulse, 2 waiting for first ISR instruction
  int          m_win;
  bit          m_hi;
  logic [15:0] m_vec;
  bit   [1:0]  m_ins;
  bit          m_fl[2];
  bit          m_skip;

  task automatic model_reset;
    q0.delete(); q1.delete();
    for (int i = 0; i <= SYNC; i++) begin
      q0.push_back(1'b1);
      q1.push_back(1'b1);
    end
    m_phase = 0; m_win = 0; m_hi = 0; m_vec = 16'h0000;
    m_ins = 2'b00; m_fl[0] = 0; m_fl[1] = 0; m_skip = 0;
  endtask

  task automatic model_step;
    bit s0, s1, f0, f1, issuing, elig, hi;
    bit raw[5];
    int best, best_rank, rank;
    s0 = q0[1]; f0 = q0[0] & !s0;
    s1 = q1[1]; f1 = q1[0] & !s1;
    raw[0] = i_it0 ? m_fl[0] : !s0;
    raw[1] = i_tf0;
    raw[2] = i_it1 ? m_fl[1] : !s1;
    raw[3] = i_tf1;
    raw[4] = i_ser;
    best = -1; best_rank = 100;
    for (int i = 0; i < 5; i++) begin
      if (raw[i] && i_ie[i] && i_ie[7]) begin
        rank = (i_ip[i] ? 0 : 10) + i;
        if (rank < best_rank) begin best_rank = rank; best = i; end
      end
    end
    issuing = (m_phase == 1);
    hi   = (best >= 0) ? i_ip[best] : 1'b0;
    elig = (m_ins == 2'b00) || (PREEMPT && hi && !m_ins[1]);
    if (i_reti) begin
      if (m_ins[1]) m_ins[1] = 0;
      else          m_ins[0] = 0;
    end
    if (issuing) m_ins[m_hi] = 1;
    m_fl[0] = i_it0 ? (f0 || (m_fl[0] && !(issuing && m_win == 0))) : 1'b0;
    m_fl[1] = i_it1 ? (f1 || (m_fl[1] && !(issuing && m_win == 2))) : 1'b0;
    if (i_reti)                          m_skip = 1;
    else if (i_boundary && m_phase != 1) m_skip = 0 | (m_skip & 1'b0);
    case (m_phase)
      0: if (i_boundary && !(m_phase == 0 && m_skip_prev_hold()) && best >= 0 && elig) begin
           m_phase = 1; m_win = best; m_hi = hi;
           m_vec = 16'(int'(VBASE) + VSTRIDE * best);
         end
      1: m_phase = 2;
      default: if (i_boundary) m_phase = 0;
    endcase
    q0.push_back(i_int0_n); void'(q0.pop_front());
    q1.push_back(i_int1_n); void'(q1.pop_front());
  endtask

  // Skip state as it was before this step's update (captured by model_step's caller).
  bit skip_before;
  function automatic bit m_skip_prev_hold();
    return skip_before;
  endfunction

  function automatic logic [31:0] model_out();
    bit p;
    p = (m_phase == 1);
    return {9'd0, p, p && m_win == 1, p && m_win == 3, m_fl[1], m_fl[0], m_ins, m_vec};
  endfunction

  function automatic logic [31:0] dut_out();
    return {9'd0, o_int_pend, o_tf0_clr, o_tf1_clr, o_ie_flags, o_in_service, o_vector};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{8'h8A, 5'h00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h000B, 1'b1, 1'b0, 2'b01};
    tbl[1] = '{8'h9F, 5'h10, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0023, 1'b0, 1'b0, 2'b10};
    tbl[2] = '{8'h08, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00};
    tbl[3] = '{8'h88, 5'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h001B, 1'b0, 1'b1, 2'b01};
    tbl[4] = '{8'h9A, 5'h08, 1'b1, 1'b1, 1'b1, 1'b1, 16'h001B, 1'b0, 1'b1, 2'b10};
    tbl[5] = '{8'h90, 5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0023, 1'b0, 1'b0, 2'b01};
    tbl[6] = '{8'h9F, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00};
    tbl[7] = '{8'h92, 5'h12, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 1'b1, 1'b0, 2'b10};

    // Reset state
    idle_inputs();
    i_rst = 1'b0;
    tick();
    check("rst_pend", o_int_pend, 1'b0);
    check("rst_vector", o_vector, 16'h0000);
    check("rst_in_service", o_in_service, 2'b00);
    check("rst_ie_flags", o_ie_flags, 2'b00);
    check("rst_tf_clr", {o_tf0_clr, o_tf1_clr}, 2'b00);

    // Table: arbitration / masking from a clean reset
    for (int k = 0; k < 8; k++) begin
      do_reset();
      i_ie = tbl[k].ie; i_ip = tbl[k].ip;
      i_tf0 = tbl[k].tf0; i_tf1 = tbl[k].tf1; i_ser = tbl[k].ser;
      repeat (2) tick();
      pulse_boundary();
      check($sformatf("tbl%0d_pend", k), o_int_pend, tbl[k].exp_pend);
      check($sformatf("tbl%0d_vector", k), o_vector, tbl[k].exp_vec);
      check($sformatf("tbl%0d_tf0_clr", k), o_tf0_clr, tbl[k].exp_tf0clr);
      check($sformatf("tbl%0d_tf1_clr", k), o_tf1_clr, tbl[k].exp_tf1clr);
      tick();
      check($sformatf("tbl%0d_in_service", k), o_in_service, tbl[k].exp_ins);
      check($sformatf("tbl%0d_pend_one_cycle", k), o_int_pend, 1'b0);
    end

    // INT0 falling edge: flag set, vectored, flag cleared
    do_reset();
    i_ie = 8'h81; i_it0 = 1'b1;
    pulse_int0();
    check("int0_flag_set", o_ie_flags, 2'b01);
    pulse_boundary();
    check("int0_pend", o_int_pend, 1'b1);
    check("int0_vector", o_vector, 16'h0003);
    tick();
    check("int0_flag_cleared", o_ie_flags, 2'b00);
    check("int0_in_service", o_in_service, 2'b01);
    check("int0_pend_drop", o_int_pend, 1'b0);

    // TF0 then TF1 after RETI and a skipped boundary
    do_reset();
    i_ie = 8'h8A; i_tf0 = 1'b1; i_tf1 = 1'b1;
    tick();
    pulse_boundary();
    check("tf_first_vector", o_vector, 16'h000B);
    check("tf_first_clr", {o_tf0_clr, o_tf1_clr}, 2'b10);
    i_tf0 = 1'b0;
    tick();
    pulse_boundary();
    pulse_boundary();
    check("tf_busy_no_issue", o_int_pend, 1'b0);
    pulse_reti();
    check("tf_reti_clear", o_in_service, 2'b00);
    pulse_boundary();
    check("tf_skip_boundary", o_int_pend, 1'b0);
    pulse_boundary();
    check("tf_second_pend", o_int_pend, 1'b1);
    check("tf_second_vector", o_vector, 16'h001B);
    check("tf_second_clr", {o_tf0_clr, o_tf1_clr}, 2'b01);

    // Nesting: low-level INT0 active, high-priority serial arrives
    do_reset();
    i_ie = 8'h91; i_ip = 5'h10; i_it0 = 1'b1;
    pulse_int0();
    pulse_boundary();
    check("nest_low_vector", o_vector, 16'h0003);
    tick();
    check("nest_low_in_service", o_in_service, 2'b01);
    pulse_boundary();
    i_ser = 1'b1;
    tick();
    pulse_boundary();
    if (PREEMPT) begin
      check("nest_pre_pend", o_int_pend, 1'b1);
      check("nest_pre_vector", o_vector, 16'h0023);
      tick();
      check("nest_pre_in_service", o_in_service, 2'b11);
      pulse_boundary();
      pulse_reti();
      check("nest_pre_reti", o_in_service, 2'b01);
    end else begin
      check("nest_blocked_pend", o_int_pend, 1'b0);
      check("nest_blocked_in_service", o_in_service, 2'b01);
      pulse_reti();
      check("nest_reti", o_in_service, 2'b00);
      pulse_boundary();
      check("nest_skip", o_int_pend, 1'b0);
      pulse_boundary();
      check("nest_late_pend", o_int_pend, 1'b1);
      check("nest_late_vector", o_vector, 16'h0023);
      tick();
      check("nest_late_in_service", o_in_service, 2'b10);
    end

    // Level-mode INT1: re-issues while held low
    do_reset();
    i_ie = 8'h84; i_it1 = 1'b0; i_int1_n = 1'b0;
    repeat (3) tick();
    pulse_boundary();
    check("lvl_first_vector", o_vector, 16'h0013);
    check("lvl_first_pend", o_int_pend, 1'b1);
    tick();
    check("lvl_flags_zero", o_ie_flags, 2'b00);
    check("lvl_in_service", o_in_service, 2'b01);
    for (int r = 0; r < 2; r++) begin
      pulse_boundary();
      pulse_boundary();
      check($sformatf("lvl%0d_busy", r), o_int_pend, 1'b0);
      pulse_reti();
      pulse_boundary();
      check($sformatf("lvl%0d_skip", r), o_int_pend, 1'b0);
      pulse_boundary();
      check($sformatf("lvl%0d_reissue", r), o_int_pend, 1'b1);
      check($sformatf("lvl%0d_vector", r), o_vector, 16'h0013);
      tick();
    end
    pulse_boundary();
    i_int1_n = 1'b1;
    pulse_reti();
    repeat (3) tick();
    pulse_boundary();
    pulse_boundary();
    check("lvl_released_a", o_int_pend, 1'b0);
    pulse_boundary();
    check("lvl_released_b", o_int_pend, 1'b0);
    check("lvl_released_ins", o_in_service, 2'b00);

    // Asynchronous reset in the middle of an issue
    do_reset();
    i_ie = 8'h82; i_tf0 = 1'b1;
    tick();
    pulse_boundary();
    check("arst_pre_pend", o_int_pend, 1'b1);
    #1 i_rst = 1'b0;
    #1;
    check("arst_pend", o_int_pend, 1'b0);
    check("arst_vector", o_vector, 16'h0000);
    check("arst_in_service", o_in_service, 2'b00);
    check("arst_tf0_clr", o_tf0_clr, 1'b0);
    i_tf0 = 1'b0;
    tick();
    i_rst = 1'b1;
    pulse_boundary();
    pulse_boundary();
    check("arst_no_issue", o_int_pend, 1'b0);
    i_tf0 = 1'b1;
    tick();
    pulse_boundary();
    check("arst_new_pend", o_int_pend, 1'b1);
    check("arst_new_vector", o_vector, 16'h000B);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    i_ie = 8'h9F;
    for (int c = 0; c < 3000; c++) begin
      check("rand_outputs", dut_out(), model_out());
      if ($urandom_range(0, 7) == 0) i_int0_n = ~i_int0_n;
      if ($urandom_range(0, 7) == 0) i_int1_n = ~i_int1_n;
      if ($urandom_range(0, 9) == 0) i_tf0 = ~i_tf0;
      if ($urandom_range(0, 9) == 0) i_tf1 = ~i_tf1;
      if ($urandom_range(0, 9) == 0) i_ser = ~i_ser;
      if (c % 100 == 0) i_ie = 8'($urandom) | (($urandom_range(0, 4) != 0) ? 8'h80 : 8'h00);
      if (c % 120 == 0) i_ip = 5'($urandom);
      if (c % 150 == 0) begin
        i_it0 = 1'($urandom_range(0, 1));
        i_it1 = 1'($urandom_range(0, 1));
      end
      i_boundary = ($urandom_range(0, 2) == 0);
      i_reti     = ($urandom_range(0, 19) == 0);
      skip_before = m_skip;
      model_step();
      tick();
    end
    check("rand_final", dut_out(), model_out());
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
